lsu: RTL

// - Load/store unit downstream of the core sequencer. Takes one load or store request per

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu.sv | 130 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, AXI response codes.
package lsu_pkg;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4,
        RESP  = 3'd5
    } lsu_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication and strobes, load lane extract/extend, misalign detect.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  a,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] rext,
    output logic        misalign,
    output logic        illegal
);
    logic [31:0] rsh;

    always_comb begin
        rsh      = rd >> {a, 3'b000};
        wdata    = wd;
        wstrb    = 4'b1111;
        rext     = rd;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (size)
            SZ_BYTE: begin
                wdata = {4{wd[7:0]}};
                wstrb = 4'b0001 << a;
                rext  = {{24{sext & rsh[7]}}, rsh[7:0]};
            end
            SZ_HALF: begin
                wdata    = {2{wd[15:0]}};
                wstrb    = 4'b0011 << a;
                // half lane is chosen by a[1] only; a[0] is the misalign case
                rext     = a[1] ? {{16{sext & rd[31]}}, rd[31:16]}
                                : {{16{sext & rd[15]}}, rd[15:0]};
                misalign = a[0];
            end
            SZ_WORD: misalign = |a;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/lsu.sv
// Load/store unit: one request becomes one AXI4-Lite transaction, answered by a one-cycle pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int CHECK_ALIGN = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lsu_reqValid,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    input  logic [1:0]        lsu_size,
    input  logic              lsu_sext,
    output logic              lsu_respValid,
    output logic [31:0]       lsu_rdata,
    output logic              lsu_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);
    lsu_state_e        state, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q, rext;
    logic [1:0]        size_q, al_a, al_size;
    logic              sext_q, err_q, aw_done, w_done, aw_fin, w_fin;
    logic              misalign, illegal, fault;

    // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
    assign al_a    = (state == IDLE) ? lsu_addr[1:0] : addr_q[1:0];
    assign al_size = (state == IDLE) ? lsu_size : size_q;
    assign fault   = illegal | ((CHECK_ALIGN != 0) & misalign);

    lsu_align u_align (
        .a(al_a), .size(al_size), .sext(sext_q), .wd(wdata_q), .rd(rdata),
        .wdata(wdata), .wstrb(wstrb), .rext(rext), .misalign(misalign), .illegal(illegal)
    );

    assign araddr    = {addr_q[ADDR_W-1:2], 2'b00};
    assign awaddr    = {addr_q[ADDR_W-1:2], 2'b00};
    assign lsu_rdata = rdata_q;
    assign lsu_err   = err_q;
    assign aw_fin    = aw_done | awready;
    assign w_fin     = w_done | wready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d       = state;
        arvalid       = 1'b0;
        rready        = 1'b0;
        awvalid       = 1'b0;
        wvalid        = 1'b0;
        bready        = 1'b0;
        lsu_respValid = 1'b0;
        case (state)
            IDLE:  if (lsu_reqValid) state_d = fault ? RESP : (lsu_wen ? WR_AW : RD_A);
            RD_A: begin
                arvalid = 1'b1;
                if (arready) state_d = RD_D;
            end
            RD_D: begin
                rready = 1'b1;
                if (rvalid) state_d = RESP;
            end
            WR_AW: begin
                awvalid = ~aw_done;
                wvalid  = ~w_done;
                if (aw_fin && w_fin) state_d = WR_B;
            end
            WR_B: begin
                bready = 1'b1;
                if (bvalid) state_d = RESP;
            end
            RESP: begin
                lsu_respValid = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            // done flags live only while the write address/data phase lasts
            aw_done <= (state == WR_AW) && (state_d == WR_AW) && aw_fin;
            w_done  <= (state == WR_AW) && (state_d == WR_AW) && w_fin;
            if (state == IDLE && lsu_reqValid) begin
                addr_q  <= (CHECK_ALIGN == 0 && misalign) ? {lsu_addr[ADDR_W-1:2], 2'b00} : lsu_addr;
                wdata_q <= lsu_wdata;
                size_q  <= lsu_size;
                sext_q  <= lsu_sext;
                err_q   <= fault;
                if (fault) rdata_q <= '0;
            end else if (state == RD_D && rvalid) begin
                rdata_q <= rext;
                err_q   <= (rresp != AXI_RESP_OKAY);
            end else if (state == WR_B && bvalid) begin
                err_q   <= (bresp != AXI_RESP_OKAY);
            end
        end
    end
endmodule
